// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side command serializer for the system UART RX line.
// One accepted command expands into a fixed byte sequence (code plus operands);
// each byte goes out as start, 8 data bits LSB first, optional parity, stop.
module uart_cmd_host #(
   parameter int CLKS_PER_BIT = 8,
   parameter int GAP_BITS     = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_data,
   input  logic [7:0] cmd_opb,
   input  logic [3:0] cmd_fun,
   input  logic       par_en,
   input  logic       par_typ,
   output logic       TX_LINE,
   output logic       busy,
   output logic       byte_done,
   output logic       done
);

   localparam int CYC_W = $clog2(CLKS_PER_BIT);
   localparam int GAP_W = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             tx_q, tx_d;
   logic             byte_done_q, byte_done_d;
   logic             done_q, done_d;

   logic [7:0]       frame_q [4];
   logic [7:0]       load_d  [4];
   logic [1:0]       last_q, last_d;
   logic             par_en_q, par_typ_q;

   logic             accept;
   logic             bit_end;
   logic [7:0]       fun8;
   logic [7:0]       tx_byte;

   // Ready only in IDLE and never while reset is held.
   assign cmd_ready = (state_q == S_IDLE) && !RST;
   assign accept    = cmd_valid && cmd_ready;
   assign bit_end   = (cyc_q == CYC_LAST);
   assign fun8      = {4'b0000, cmd_fun};

   assign busy      = (state_q != S_IDLE);
   assign TX_LINE   = tx_q;
   assign byte_done = byte_done_q;
   assign done      = done_q;

   // Build the byte sequence for the command currently offered.
   always_comb begin
      load_d[0] = 8'h00;
      load_d[1] = 8'h00;
      load_d[2] = 8'h00;
      load_d[3] = 8'h00;
      last_d    = 2'd0;
      case (cmd_type)
         2'd0: begin
            load_d[0] = 8'hAA; load_d[1] = cmd_addr; load_d[2] = cmd_data;
            last_d    = 2'd2;
         end
         2'd1: begin
            load_d[0] = 8'hBB; load_d[1] = cmd_addr;
            last_d    = 2'd1;
         end
         2'd2: begin
            load_d[0] = 8'hCC; load_d[1] = cmd_data; load_d[2] = cmd_opb; load_d[3] = fun8;
            last_d    = 2'd3;
         end
         default: begin
            load_d[0] = 8'hDD; load_d[1] = fun8;
            last_d    = 2'd1;
         end
      endcase
   end

   // Capture the command and framing options at accept; held until the next accept.
   always_ff @(posedge CLK) begin
      if (accept) begin
         frame_q   <= load_d;
         last_q    <= last_d;
         par_en_q  <= par_en;
         par_typ_q <= par_typ;
      end
   end

   // State and control register; reset aborts any frame in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         gap_q       <= '0;
         tx_q        <= 1'b1;
         byte_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         gap_q       <= gap_d;
         tx_q        <= tx_d;
         byte_done_q <= byte_done_d;
         done_q      <= done_d;
      end
   end

   // Next state and counters: every state lasts whole bit periods.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      gap_d   = gap_q;
      if (state_q != S_IDLE) begin
         cyc_d = bit_end ? '0 : cyc_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               cyc_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               gap_d   = '0;
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               if (byte_q == last_q) begin
                  byte_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = (GAP_BITS == 0) ? S_START : S_GAP;
               end
            end
         end
         S_GAP: begin
            if (bit_end) begin
               if (gap_q == GAP_LAST) begin
                  gap_d   = '0;
                  state_d = S_START;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs registered from the next state so the line changes right at the edge.
   always_comb begin
      tx_byte     = frame_q[byte_d];
      tx_d        = 1'b1;
      byte_done_d = (state_q == S_STOP) && (state_d != S_STOP);
      done_d      = byte_done_d && (state_d == S_IDLE);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_byte[bit_d];
         S_PARITY: tx_d = par_typ_q ? ~^tx_byte : ^tx_byte;
         default:  tx_d = 1'b1;
      endcase
   end

endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
- Host-side command serializer that drives the system's UART receive line.
- Accepts one command per valid/ready handshake and expands it into the system command frame sequence (command code plus operand bytes).
- Serializes each byte as a UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits directly upstream of the system top's RX_IN. Used as a bench stimulus generator and as the host-side interface in FPGA bring-up.

Parameters:
- CLKS_PER_BIT, 8, CLK cycles per UART bit period; must be >= 2.
- GAP_BITS, 1, idle-high bit periods inserted between bytes of one command; 0 allowed.

Ports:
- CLK  in  1  block clock; one bit period = CLKS_PER_BIT cycles.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  2  0=reg write, 1=reg read, 2=ALU with operands, 3=ALU without operands.
- cmd_addr  in  8  register address (types 0, 1).
- cmd_data  in  8  write data (type 0) or operand A (type 2).
- cmd_opb  in  8  operand B (type 2).
- cmd_fun  in  4  ALU function (types 2, 3); sent zero-extended to 8 bits.
- par_en  in  1  1 = parity bit present.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- TX_LINE  out  1  serial output to system RX_IN; idles high.
- busy  out  1  high from accept until done.
- byte_done  out  1  one-cycle pulse after each byte's stop bit.
- done  out  1  one-cycle pulse after the last byte of a command.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: TX_LINE=1, busy=0, cmd_ready=0 while RST is high; cmd_ready=1 on the first cycle after RST deasserts. byte_done=0, done=0. Reset mid-frame aborts the command: TX_LINE=1 at the next edge, with no done or byte_done pulse.
- Frame sequences, fixed:
  - type 0: 0xAA, addr, data (3 bytes).
  - type 1: 0xBB, addr (2 bytes).
  - type 2: 0xCC, A, B, {4'b0,fun} (4 bytes).
  - type 3: 0xDD, {4'b0,fun} (2 bytes).
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready.
  - All cmd_* inputs, par_en and par_typ are captured at accept. Later input changes have no effect.
  - cmd_ready=0 from the accept edge until done.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (par_en=1) or STOP after 8 bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> GAP, or directly to START when GAP_BITS=0, if more bytes remain.
  - STOP -> IDLE on the last byte.
  - GAP -> START after GAP_BITS bit periods.
- Line levels: START drives 0; DATA drives data[i] with i = 0..7; STOP and GAP drive 1.
- Parity: even parity bit = ^data; odd parity bit = ~^data.
- Timing: if accept occurs at edge T, TX_LINE=0 from cycle T+1. Each bit holds for exactly CLKS_PER_BIT cycles; no jitter or stretching.
- Pulse timing:
  - byte_done is high during the first cycle after each stop bit ends.
  - For the last byte, done and byte_done are high in the same cycle. In that cycle busy=0, cmd_ready=1 and the FSM is in IDLE.
  - A new command accepted in that cycle starts its start bit on the next cycle: back-to-back commands have no extra idle beyond the stop bit.
- Command length in cycles, from first start-bit cycle to the end of the last stop bit: N*(10+par_en)*CLKS_PER_BIT + (N-1)*GAP_BITS*CLKS_PER_BIT, where N is the byte count.
- Counters:
  - bit-cycle counter: width clog2(CLKS_PER_BIT).
  - bit index: 0..7.
  - byte index: 0..3.
  - gap counter: 0..GAP_BITS-1.
  - All wrap to 0 on state exit.
- cmd_valid while busy is ignored and not queued.

Test Plan:
- Reset: RST=1 for 3 cycles, then 0 -> TX_LINE=1, busy=0, done=0 throughout reset; cmd_ready=1 on the first cycle after release.
- Write, even parity: CLKS_PER_BIT=4, GAP_BITS=1, par_en=1, par_typ=0, type 0, addr=0x05, data=0x3C, accept at T.
  - TX_LINE bit sequence: 0, 0,1,0,1,0,1,0,1, 0, 1 (0xAA), then 4 gap cycles high.
  - Then 0x05 frame with parity 0, then 0x3C frame with parity 0.
  - done at T+141; byte_done at T+45, T+93, T+141.
- ALU with operands, odd parity, no parity variant: type 2, A=0x07, B=0x03, fun=0x1, par_typ=1.
  - Parity bits are 1, 0, 1, 0 for CC, 07, 03, 01.
  - Repeat with par_en=0: frames are 10 bits and done arrives at T+1+4*40+3*4.
- Back-to-back: hold cmd_valid=1 with type 3 fun=0x2, then type 1 addr=0x02.
  - Second start bit begins the cycle after the first done.
  - Input changes during the first command have no effect on its bytes.
- Busy rejection: pulse cmd_valid mid-command with different data -> transmitted bytes unchanged, no second command sent.
- Mid-frame reset: assert RST during the DATA bits of byte 2 -> TX_LINE=1 next cycle, no done pulse, cmd_ready=1 after release, and a fresh command transmits correctly.
